path_fsm_bench: RTL and testbench

Parametrised successor to the team's fixed 4-bit path FSM model-checking benchmark. A W-bit state register walks a fixed encoded path with input-driven branches. New behaviour over the fixed version: a bounded retry loop with abort, restart from terminal states, an advance-enable, and a cycle counter. Registered state is decoded into property outputs (z1, z2, z3, z_hi, z_abort) that feed safety and reachability checks in the verification flow.

---
 rtl/path_fsm_bench_if.sv | 34 +++
 rtl/path_fsm_bench.sv | 135 +++++++++++++
 tb/tb_path_fsm_bench.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/path_fsm_bench_if.sv
// rtl/path_fsm_bench_if.sv - control inputs and decoded property outputs of the path FSM benchmark
//
// Ports (signals):
//   en, i1, restart        driven by master, sampled by slave
//   state[W-1:0]           current state encoding
//   loops[7:0]             retry count since reset/restart
//   cycles[CW-1:0]         enabled cycles since reset/restart (saturating)
//   z1, z2, z3, z_hi, z_abort  decoded property outputs
interface path_fsm_bench_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    logic          en;
    logic          i1;
    logic          restart;
    logic [W-1:0]  state;
    logic [7:0]    loops;
    logic [CW-1:0] cycles;
    logic          z1;
    logic          z2;
    logic          z3;
    logic          z_hi;
    logic          z_abort;

    modport master (
        output en, i1, restart,
        input  state, loops, cycles, z1, z2, z3, z_hi, z_abort
    );

    modport slave (
        input  en, i1, restart,
        output state, loops, cycles, z1, z2, z3, z_hi, z_abort
    );
endinterface

// File: rtl/path_fsm_bench.sv
// rtl/path_fsm_bench.sv - parametrised encoded-path FSM with retry loop, abort, restart and cycle counter
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   bus.en       advance enable; 0 freezes state, loops and cycles
//   bus.i1       branch select at states 2 and 5
//   bus.restart  return to 0 from terminal states 9 or 3
//   bus.state    current state encoding (W bits)
//   bus.loops    5->1 retry count, saturating at 255
//   bus.cycles   enabled cycle count, saturating at all-ones
//   bus.z1/z2/z3/z_hi/z_abort  combinational decodes of the registered state
module path_fsm_bench #(
    parameter int W        = 4,
    parameter int TARGET   = 9,
    parameter int THRESH   = 2,
    parameter int LOOP_MAX = 3,
    parameter int CW       = 8
) (
    input  logic             clk,
    input  logic             reset,
    path_fsm_bench_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SEEK    = 4'd1,
        S_BRANCH  = 4'd2,
        S_ABORT   = 4'd3,
        S_PARK4   = 4'd4,
        S_CHECK   = 4'd5,
        S_DETOUR6 = 4'd6,
        S_DETOUR7 = 4'd7,
        S_ARM     = 4'd8,
        S_DONE    = 4'd9,
        S_PRIME   = 4'd10,
        S_PARK11  = 4'd11,
        S_PARK12  = 4'd12,
        S_PARK13  = 4'd13,
        S_SKIP14  = 4'd14,
        S_SKIP15  = 4'd15
    } path_e;

    localparam logic [7:0] LM = 8'(LOOP_MAX);

    logic [W-1:0]  state_q, state_d;
    logic [7:0]    loops_q, loops_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          hi;

    function automatic logic [W-1:0] ext(input path_e s);
        logic [W-1:0] r;
        r      = '0;
        r[3:0] = s;
        return r;
    endfunction

    // Bits above [3:0] are never reachable; any set bit marks a corrupted state.
    generate
        if (W > 4) begin : g_hi
            assign hi = |state_q[W-1:4];
        end else begin : g_nohi
            assign hi = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= '0;
            loops_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            loops_q  <= loops_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        loops_d  = loops_q;
        cycles_d = cycles_q;
        if (bus.en) begin
            if (cycles_q != '1) begin
                cycles_d = cycles_q + 1'b1;
            end
            if (hi) begin
                // Recovery to the start; the retry history is deliberately kept.
                state_d = '0;
            end else begin
                case (state_q[3:0])
                    S_IDLE:    state_d = ext(S_ARM);
                    S_ARM:     state_d = ext(S_PRIME);
                    S_PRIME:   state_d = ext(S_SEEK);
                    S_SEEK:    state_d = ext(S_BRANCH);
                    S_BRANCH:  state_d = bus.i1 ? ext(S_CHECK) : ext(S_DETOUR6);
                    S_DETOUR6: state_d = ext(S_DETOUR7);
                    S_DETOUR7: state_d = ext(S_CHECK);
                    S_CHECK: begin
                        if (bus.i1) begin
                            state_d = ext(S_DONE);
                        end else if ((LOOP_MAX == 0) || (loops_q < LM)) begin
                            state_d = ext(S_SEEK);
                            if (loops_q != 8'hff) begin
                                loops_d = loops_q + 8'd1;
                            end
                        end else begin
                            state_d = ext(S_ABORT);
                        end
                    end
                    S_DONE, S_ABORT: begin
                        // The restart edge clears the counter rather than counting itself.
                        if (bus.restart) begin
                            state_d  = '0;
                            loops_d  = '0;
                            cycles_d = '0;
                        end
                    end
                    S_SKIP14, S_SKIP15: state_d = ext(S_DONE);
                    default:            state_d = state_q;
                endcase
            end
        end
    end

    assign bus.state   = state_q;
    assign bus.loops   = loops_q;
    assign bus.cycles  = cycles_q;
    assign bus.z1      = state_q[3] & state_q[0];
    assign bus.z2      = (state_q == W'(TARGET));
    assign bus.z3      = (state_q > W'(THRESH));
    assign bus.z_hi    = hi;
    assign bus.z_abort = (state_q == ext(S_ABORT));

endmodule

// File: tb/tb_path_fsm_bench.sv
// tb/tb_path_fsm_bench.sv - directed table-driven bench for path_fsm_bench
module tb_path_fsm_bench;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic i1 = 1'b0;
    logic restart = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    path_fsm_bench_if #(.W(4), .CW(8)) if4 ();
    path_fsm_bench_if #(.W(6), .CW(8)) if6 ();
    path_fsm_bench_if #(.W(4), .CW(8)) if0 ();

    assign if4.en = en;  assign if4.i1 = i1;  assign if4.restart = restart;
    assign if6.en = en;  assign if6.i1 = i1;  assign if6.restart = restart;
    assign if0.en = en;  assign if0.i1 = i1;  assign if0.restart = restart;

    path_fsm_bench #(.W(4), .LOOP_MAX(3)) u4 (.clk(clk), .reset(reset), .bus(if4));
    path_fsm_bench #(.W(6), .LOOP_MAX(3)) u6 (.clk(clk), .reset(reset), .bus(if6));
    path_fsm_bench #(.W(4), .LOOP_MAX(0)) u0 (.clk(clk), .reset(reset), .bus(if0));

    typedef struct {
        logic       en;
        logic       i1;
        logic       restart;
        logic [3:0] st;
        logic [7:0] lp;
        logic [7:0] cy;
        logic       z1;
        logic       z2;
        logic       z3;
        logic       zab;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic e, logic b, logic r, logic [3:0] st, logic [7:0] lp,
                                logic [7:0] cy, logic z1, logic z2, logic z3, logic zab);
        vec_t v;
        v.en = e; v.i1 = b; v.restart = r; v.st = st; v.lp = lp; v.cy = cy;
        v.z1 = z1; v.z2 = z2; v.z3 = z3; v.zab = zab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] obs4();
        return {if4.state, if4.loops, if4.cycles, if4.z1, if4.z2, if4.z3, if4.z_hi, if4.z_abort};
    endfunction

    initial begin
        int at5[4];
        logic aborted;

        // Path i1=1, hold at 9, restart masked by en=0, restart, then en alternating.
        vecs[0]  = mk(1, 1, 0, 4'd8,  0, 1, 0, 0, 1, 0);
        vecs[1]  = mk(1, 1, 0, 4'd10, 0, 2, 0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 0, 4'd1,  0, 3, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 4'd2,  0, 4, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 4'd5,  0, 5, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1, 0, 4'd9,  0, 6, 1, 1, 1, 0);
        vecs[6]  = mk(1, 1, 0, 4'd9,  0, 7, 1, 1, 1, 0);
        vecs[7]  = mk(0, 1, 1, 4'd9,  0, 7, 1, 1, 1, 0);
        vecs[8]  = mk(1, 1, 1, 4'd0,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 4'd0,  0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 4'd8,  0, 1, 0, 0, 1, 0);
        vecs[11] = mk(0, 1, 0, 4'd8,  0, 1, 0, 0, 1, 0);
        vecs[12] = mk(1, 1, 0, 4'd10, 0, 2, 0, 0, 1, 0);
        vecs[13] = mk(0, 1, 0, 4'd10, 0, 2, 0, 0, 1, 0);
        vecs[14] = mk(1, 1, 0, 4'd1,  0, 3, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 4'd1,  0, 3, 0, 0, 0, 0);
        vecs[16] = mk(1, 1, 0, 4'd2,  0, 4, 0, 0, 0, 0);
        vecs[17] = mk(0, 1, 0, 4'd2,  0, 4, 0, 0, 0, 0);
        vecs[18] = mk(1, 1, 0, 4'd5,  0, 5, 0, 0, 1, 0);
        vecs[19] = mk(0, 1, 0, 4'd5,  0, 5, 0, 0, 1, 0);
        vecs[20] = mk(1, 1, 0, 4'd9,  0, 6, 1, 1, 1, 0);

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        chk("reset", 64'(obs4()), 64'd0);
        reset = 1'b1;

        for (int k = 0; k < 21; k++) begin
            en = vecs[k].en; i1 = vecs[k].i1; restart = vecs[k].restart;
            tick();
            chk($sformatf("vec%0d", k), 64'(obs4()),
                64'({vecs[k].st, vecs[k].lp, vecs[k].cy, vecs[k].z1, vecs[k].z2,
                     vecs[k].z3, 1'b0, vecs[k].zab}));
        end
        restart = 1'b0;

        // Retry loop to abort
        reset = 1'b0; tick(); reset = 1'b1;
        en = 1'b1; i1 = 1'b0;
        at5 = '{7, 12, 17, 22};
        for (int e = 1; e <= 23; e++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (e == at5[k]) begin
                    chk($sformatf("loop_at5_e%0d", e), 64'({if4.state, if4.loops}),
                        64'({4'd5, 8'(k)}));
                end
            end
        end
        chk("abort", 64'({if4.state, if4.loops, if4.z_abort}), 64'({4'd3, 8'd3, 1'b1}));
        chk("unlimited_no_abort", 64'({if0.state, if0.loops, if0.z_abort}),
            64'({4'd1, 8'd4, 1'b0}));
        i1 = 1'b1;
        for (int e = 0; e < 3; e++) tick();
        chk("abort_hold", 64'({if4.state, if4.z_abort}), 64'({4'd3, 1'b1}));

        // Restart from abort, then replay to 9
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_abort", 64'({if4.state, if4.loops, if4.cycles}), 64'd0);
        for (int e = 0; e < 6; e++) tick();
        chk("replay_done", 64'({if4.state, if4.cycles, if4.z1, if4.z2}),
            64'({4'd9, 8'd6, 1'b1, 1'b1}));

        // Backdoor-corrupted encodings on the wide instance
        force u6.state_q = 6'd37;
        #1;
        chk("force37_hi", 64'({if6.state, if6.z_hi}), 64'({6'd37, 1'b1}));
        release u6.state_q;
        tick();
        chk("recover37", 64'({if6.state, if6.z_hi}), 64'({6'd0, 1'b0}));
        force u6.state_q = 6'd14;
        #1;
        release u6.state_q;
        tick();
        chk("skip14", 64'({if6.state, if6.z_hi}), 64'({6'd9, 1'b0}));
        chk("narrow_zhi", 64'(if4.z_hi), 64'd0);

        // Reset mid-loop at state 7 with loops 2
        reset = 1'b0; tick(); reset = 1'b1;
        i1 = 1'b0;
        for (int e = 0; e < 16; e++) tick();
        chk("mid_loop", 64'({if4.state, if4.loops, if4.cycles}), 64'({4'd7, 8'd2, 8'd16}));
        reset = 1'b0; restart = 1'b1;
        tick();
        chk("mid_reset", 64'({if4.state, if4.loops, if4.cycles}), 64'd0);
        reset = 1'b1; restart = 1'b0;

        // Unlimited retries: 300 loops, loops and cycles saturate
        aborted = 1'b0;
        for (int e = 0; e < 1503; e++) begin
            tick();
            if (if0.state == 4'd3) aborted = 1'b1;
        end
        chk("unlimited_never_abort", 64'(aborted), 64'd0);
        chk("unlimited_sat", 64'({if0.state, if0.loops, if0.cycles}),
            64'({4'd1, 8'd255, 8'd255}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
